// File: rtl/bank_mapper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bank_mapper_pkg
// Description : Shared types and constants for the bank mapper: lock FSM
//               state type, lock key bytes and default register bases.
// Revision    : 1.0 - initial release
// ============================================================================
package bank_mapper_pkg;

    typedef enum logic [1:0] {
        LOCK_UNLOCKED = 2'd0,
        LOCK_KEY1     = 2'd1,
        LOCK_LOCKED   = 2'd2
    } lock_state_t;

    localparam logic [7:0] LOCK_KEY_1        = 8'hA5;
    localparam logic [7:0] LOCK_KEY_2        = 8'h5A;
    localparam logic [7:0] LOCK_CMD          = 8'h00;
    localparam logic [7:0] REG_BASE_DEFAULT  = 8'hD0;
    localparam logic [7:0] MASK_BASE_DEFAULT = 8'hE4;

endpackage
`default_nettype wire

// File: rtl/bank_mapper_bus_write_sync.sv
`default_nettype none
// ============================================================================
// Module      : bus_write_sync
// Description : Brings the asynchronous cartridge I/O write strobe into the
//               clk domain (2-flop synchroniser), captures {addr, data} while
//               the write is seen active, and pulses o_commit for one cycle
//               on the synchronised end of the write.
// Ports       : clk, rst (async, active high)
//               i_io_write        raw write strobe, active high
//               i_addr, i_data    bus address / data bytes
//               o_commit          one-cycle commit pulse
//               o_addr, o_data    last captured address / data
// Revision    : 1.0 - initial release
// ============================================================================
module bus_write_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_io_write,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_data,
    output logic       o_commit,
    output logic [7:0] o_addr,
    output logic [7:0] o_data
);

    logic        r_sync1_q, w_sync1_d;
    logic        r_sync2_q, w_sync2_d;
    logic        r_sync3_q, w_sync3_d;
    logic [15:0] r_cap_q,   w_cap_d;

    always_comb begin
        w_sync1_d = i_io_write;
        w_sync2_d = r_sync1_q;
        w_sync3_d = r_sync2_q;
        // Stage 1 high means the bus has been driving the write for at least
        // one edge; keep re-sampling so the final capture is the settled value.
        w_cap_d   = r_sync1_q ? {i_addr, i_data} : r_cap_q;
    end

    // Everything resets to idle (0) so no falling edge can be seen on the
    // first synchronised sample after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1_q <= 1'b0;
            r_sync2_q <= 1'b0;
            r_sync3_q <= 1'b0;
            r_cap_q   <= 16'h0000;
        end else begin
            r_sync1_q <= w_sync1_d;
            r_sync2_q <= w_sync2_d;
            r_sync3_q <= w_sync3_d;
            r_cap_q   <= w_cap_d;
        end
    end

    assign o_commit = r_sync3_q & ~r_sync2_q;
    assign o_addr   = r_cap_q[15:8];
    assign o_data   = r_cap_q[7:0];

endmodule
`default_nettype wire

// File: rtl/bank_mapper.sv
`default_nettype none
// ============================================================================
// Module      : bank_mapper
// Description : Parametrised bank register file with per-window masking.
//               Bank numbers are written as a staged low byte followed by an
//               atomic high-byte commit; masked results are registered onto
//               BankOut. Optional key-sequence lock protects mask/apply,
//               enabled by defining BANK_MAPPER_LOCK_EN.
// Ports       : FastClk, Reset (async, active high)
//               nSel, nIO, nWE    raw bus strobes, active low
//               RegAddr, WriteData register address / write byte
//               BankOut           registered masked bank per window
//               RegOut, RegAck    combinational readback byte / address hit
//               Locked            mask registers write-protected
// Revision    : 1.0 - initial release
// ============================================================================
module bank_mapper
    import bank_mapper_pkg::*;
#(
    parameter int         NUM_WINDOWS = 3,
    parameter int         BANK_WIDTH  = 10,
    parameter logic [7:0] REG_BASE    = REG_BASE_DEFAULT,
    parameter logic [7:0] MASK_BASE   = MASK_BASE_DEFAULT
) (
    input  logic                              FastClk,
    input  logic                              Reset,
    input  logic                              nSel,
    input  logic                              nIO,
    input  logic                              nWE,
    input  logic [7:0]                        RegAddr,
    input  logic [7:0]                        WriteData,
    output logic [NUM_WINDOWS*BANK_WIDTH-1:0] BankOut,
    output logic [7:0]                        RegOut,
    output logic                              RegAck,
    output logic                              Locked
);

    localparam int         C_HW       = BANK_WIDTH - 8;
    localparam logic [7:0] C_MASK_LO  = MASK_BASE;
    localparam logic [7:0] C_MASK_HI  = MASK_BASE + 8'd1;
    localparam logic [7:0] C_APPLY    = MASK_BASE + 8'd2;
    localparam logic [7:0] C_LOCK     = MASK_BASE + 8'd3;

    logic                  w_io_write;
    logic                  w_commit;
    logic [7:0]            w_cap_addr;
    logic [7:0]            w_cap_data;
    logic [7:0]            w_wr_off;
    logic [7:0]            w_rd_off;
    logic                  w_mask_we;
    logic                  w_unused_bits;

    logic [BANK_WIDTH-1:0] r_bank_q  [NUM_WINDOWS];
    logic [BANK_WIDTH-1:0] w_bank_d  [NUM_WINDOWS];
    logic [7:0]            r_stage_q [NUM_WINDOWS];
    logic [7:0]            w_stage_d [NUM_WINDOWS];
    logic [BANK_WIDTH-1:0] r_mask_q,  w_mask_d;
    logic [NUM_WINDOWS-1:0] r_apply_q, w_apply_d;
    logic [NUM_WINDOWS*BANK_WIDTH-1:0] r_bankout_q, w_bankout_d;
    logic [7:0]            w_rd_data;
    logic                  w_rd_ack;

    assign w_io_write = ~nSel & ~nIO & ~nWE;

    bus_write_sync u_sync (
        .clk        (FastClk),
        .rst        (Reset),
        .i_io_write (w_io_write),
        .i_addr     (RegAddr),
        .i_data     (WriteData),
        .o_commit   (w_commit),
        .o_addr     (w_cap_addr),
        .o_data     (w_cap_data)
    );

    // Captured data bits above the bank/apply widths have no destination.
    assign w_unused_bits = ^w_cap_data;

    assign w_wr_off = w_cap_addr - REG_BASE;
    assign w_rd_off = RegAddr - REG_BASE;

    // ------------------------------------------------------------------------
    // Lock state
    // ------------------------------------------------------------------------
`ifdef BANK_MAPPER_LOCK_EN
    lock_state_t r_lock_q, w_lock_d;

    always_comb begin
        w_lock_d = r_lock_q;
        if (w_commit) begin
            case (r_lock_q)
                LOCK_UNLOCKED: if (w_cap_addr == C_LOCK && w_cap_data == LOCK_CMD)
                                   w_lock_d = LOCK_LOCKED;
                LOCK_LOCKED:   if (w_cap_addr == C_LOCK && w_cap_data == LOCK_KEY_1)
                                   w_lock_d = LOCK_KEY1;
                // The second key must be the very next commit of any kind.
                LOCK_KEY1:     w_lock_d = (w_cap_addr == C_LOCK && w_cap_data == LOCK_KEY_2)
                                          ? LOCK_UNLOCKED : LOCK_LOCKED;
                default:       w_lock_d = LOCK_LOCKED;
            endcase
        end
    end

    always_ff @(posedge FastClk or posedge Reset) begin
        if (Reset) r_lock_q <= LOCK_UNLOCKED;
        else       r_lock_q <= w_lock_d;
    end

    assign w_mask_we = (r_lock_q == LOCK_UNLOCKED);
`else
    assign w_mask_we = 1'b1;
`endif

    assign Locked = ~w_mask_we;

    // ------------------------------------------------------------------------
    // Register updates (only on the commit pulse)
    // ------------------------------------------------------------------------
    always_comb begin
        w_bank_d  = r_bank_q;
        w_stage_d = r_stage_q;
        w_mask_d  = r_mask_q;
        w_apply_d = r_apply_q;
        if (w_commit) begin
            for (int n = 0; n < NUM_WINDOWS; n++) begin
                if (w_wr_off == 8'(2 * n)) begin
                    w_stage_d[n] = w_cap_data;
                end else if (w_wr_off == 8'(2 * n + 1)) begin
                    w_bank_d[n]  = {w_cap_data[C_HW-1:0], r_stage_q[n]};
                    // Staging mirrors the new committed low byte, which is
                    // exactly the staged byte just used.
                    w_stage_d[n] = r_stage_q[n];
                end
            end
            if (w_mask_we) begin
                if (w_cap_addr == C_MASK_LO) w_mask_d[7:0]            = w_cap_data;
                if (w_cap_addr == C_MASK_HI) w_mask_d[BANK_WIDTH-1:8] = w_cap_data[C_HW-1:0];
                if (w_cap_addr == C_APPLY)   w_apply_d                = w_cap_data[NUM_WINDOWS-1:0];
            end
        end
    end

    always_comb begin
        w_bankout_d = '0;
        for (int n = 0; n < NUM_WINDOWS; n++) begin
            w_bankout_d[n*BANK_WIDTH +: BANK_WIDTH] =
                r_apply_q[n] ? (r_bank_q[n] & r_mask_q) : r_bank_q[n];
        end
    end

    always_ff @(posedge FastClk or posedge Reset) begin
        if (Reset) begin
            for (int n = 0; n < NUM_WINDOWS; n++) begin
                r_bank_q[n]  <= '1;
                r_stage_q[n] <= '1;
            end
            r_mask_q    <= '1;
            r_apply_q   <= '1;
            r_bankout_q <= '1;
        end else begin
            r_bank_q    <= w_bank_d;
            r_stage_q   <= w_stage_d;
            r_mask_q    <= w_mask_d;
            r_apply_q   <= w_apply_d;
            r_bankout_q <= w_bankout_d;
        end
    end

    assign BankOut = r_bankout_q;

    // ------------------------------------------------------------------------
    // Readback: committed values only, never staging
    // ------------------------------------------------------------------------
    always_comb begin
        w_rd_data = 8'h00;
        w_rd_ack  = 1'b0;
        for (int n = 0; n < NUM_WINDOWS; n++) begin
            if (w_rd_off == 8'(2 * n)) begin
                w_rd_ack  = 1'b1;
                w_rd_data = r_bank_q[n][7:0];
            end else if (w_rd_off == 8'(2 * n + 1)) begin
                w_rd_ack  = 1'b1;
                w_rd_data = 8'(r_bank_q[n][BANK_WIDTH-1:8]);
            end
        end
        if (RegAddr == C_MASK_LO) begin
            w_rd_ack  = 1'b1;
            w_rd_data = r_mask_q[7:0];
        end
        if (RegAddr == C_MASK_HI) begin
            w_rd_ack  = 1'b1;
            w_rd_data = 8'(r_mask_q[BANK_WIDTH-1:8]);
        end
        if (RegAddr == C_APPLY) begin
            w_rd_ack  = 1'b1;
            w_rd_data = 8'(r_apply_q);
        end
        if (RegAddr == C_LOCK) begin
            w_rd_ack  = 1'b1;
            w_rd_data = {7'h00, Locked};
        end
    end

    assign RegOut = w_rd_data;
    assign RegAck = w_rd_ack;

endmodule
`default_nettype wire

// File: tb/tb_bank_mapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_bank_mapper
// Description : Self-checking bench for bank_mapper. A behavioural model of
//               the register file is updated at commit time; a compare
//               process checks BankOut and Locked every cycle, and readback
//               is checked against the model after each write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bank_mapper;

    localparam int NW    = 3;
    localparam int BW    = 10;
    localparam int HMASK = (1 << (BW - 8)) - 1;
    localparam int FULL  = (1 << BW) - 1;

    logic              clk;
    logic              Reset;
    logic              nSel, nIO, nWE;
    logic [7:0]        RegAddr, WriteData;
    logic [NW*BW-1:0]  BankOut;
    logic [7:0]        RegOut;
    logic              RegAck;
    logic              Locked;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 0;

    // Model state
    int m_bank  [8];
    int m_stage [8];
    int m_mask;
    int m_apply;
    int m_lock;                       // 0 unlocked, 1 key1, 2 locked
    logic [NW*BW-1:0] exp_bankout;

    bank_mapper dut (
        .FastClk   (clk),
        .Reset     (Reset),
        .nSel      (nSel),
        .nIO       (nIO),
        .nWE       (nWE),
        .RegAddr   (RegAddr),
        .WriteData (WriteData),
        .BankOut   (BankOut),
        .RegOut    (RegOut),
        .RegAck    (RegAck),
        .Locked    (Locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [NW*BW-1:0] model_bankout();
        logic [NW*BW-1:0] r;
        int v;
        r = '0;
        for (int n = 0; n < NW; n++) begin
            v = m_bank[n];
            if (((m_apply >> n) & 1) != 0) v = v & m_mask;
            r[n*BW +: BW] = v[BW-1:0];
        end
        return r;
    endfunction

    function automatic void model_reset();
        for (int n = 0; n < 8; n++) begin
            m_bank[n]  = FULL;
            m_stage[n] = 'hFF;
        end
        m_mask  = FULL;
        m_apply = (1 << NW) - 1;
        m_lock  = 0;
        exp_bankout = model_bankout();
    endfunction

    function automatic void model_commit(input int a, input int d);
        bit ok;
        int n;
        ok = (m_lock == 0);
        if (a >= 'hD0 && a < 'hD0 + 2 * NW) begin
            n = (a - 'hD0) / 2;
            if ((a % 2) == 0) begin
                m_stage[n] = d;
            end else begin
                m_bank[n]  = ((d & HMASK) << 8) | m_stage[n];
                m_stage[n] = m_bank[n] & 'hFF;
            end
        end
        if (ok) begin
            if (a == 'hE4) m_mask  = (m_mask & ~'hFF & FULL) | d;
            if (a == 'hE5) m_mask  = (m_mask & 'hFF) | ((d & HMASK) << 8);
            if (a == 'hE6) m_apply = d & ((1 << NW) - 1);
        end
`ifdef BANK_MAPPER_LOCK_EN
        if (m_lock == 0) begin
            if (a == 'hE7 && d == 'h00) m_lock = 2;
        end else if (m_lock == 2) begin
            if (a == 'hE7 && d == 'hA5) m_lock = 1;
        end else begin
            m_lock = (a == 'hE7 && d == 'h5A) ? 0 : 2;
        end
`endif
    endfunction

    function automatic void model_read(input int a, output logic ack, output logic [7:0] d);
        int n;
        int v;
        ack = 1'b0;
        v   = 0;
        if (a >= 'hD0 && a < 'hD0 + 2 * NW) begin
            n   = (a - 'hD0) / 2;
            ack = 1'b1;
            v   = ((a % 2) == 0) ? (m_bank[n] & 'hFF) : (m_bank[n] >> 8);
        end
        if (a == 'hE4) begin ack = 1'b1; v = m_mask & 'hFF; end
        if (a == 'hE5) begin ack = 1'b1; v = m_mask >> 8;   end
        if (a == 'hE6) begin ack = 1'b1; v = m_apply;       end
        if (a == 'hE7) begin ack = 1'b1; v = (m_lock != 0) ? 1 : 0; end
        d = v[7:0];
    endfunction

    // Per-cycle compare of registered outputs against the model.
    initial begin
        wait (cmp_en);
        forever begin
            @(negedge clk);
            check("bankout", 32'(BankOut), 32'(exp_bankout));
            check("locked", 32'(Locked), (m_lock != 0) ? 32'd1 : 32'd0);
        end
    end

    // One bus write; the model commits after edge 2 and BankOut moves at edge 3
    // counted from the first edge that samples nWE high.
    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        RegAddr = a; WriteData = d;
        nSel = 1'b0; nIO = 1'b0; nWE = 1'b0;
        repeat (4) @(negedge clk);
        nWE = 1'b1;
        @(posedge clk);               // edge 0
        @(posedge clk);               // edge 1
        @(posedge clk);               // edge 2
        model_commit(int'(a), int'(d));
        @(posedge clk);               // edge 3
        exp_bankout = model_bankout();
        @(negedge clk);
        nSel = 1'b1; nIO = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_read(input logic [7:0] a);
        logic       eack;
        logic [7:0] ed;
        @(negedge clk);
        RegAddr = a;
        #1;
        model_read(int'(a), eack, ed);
        check("regack", 32'(RegAck), 32'(eack));
        check("regout", 32'(RegOut), 32'(ed));
    endtask

    task automatic lit_read(input string name, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        RegAddr = a;
        #1;
        check({name, "_ack"}, 32'(RegAck), 32'd1);
        check(name, 32'(RegOut), 32'(d));
    endtask

    function automatic logic [BW-1:0] win(input int n);
        return BankOut[n*BW +: BW];
    endfunction

    initial begin
        logic [7:0] addrs [10];
        logic [7:0] keys  [3];
        logic [7:0] a, d;
        int sel;

        addrs = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hE4, 8'hE5, 8'hE6, 8'hE7};
        keys  = '{8'h00, 8'hA5, 8'h5A};

        Reset = 1'b1; nSel = 1'b1; nIO = 1'b1; nWE = 1'b1;
        RegAddr = 8'h00; WriteData = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #2 Reset = 1'b0;
        cmp_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_bankout", 32'(BankOut), 32'h3FFF_FFFF);
        check("rst_locked", 32'(Locked), 32'd0);
        lit_read("rst_d1", 8'hD1, 8'h03);
        @(negedge clk); RegAddr = 8'hC0; #1;
        check("unmapped_ack", 32'(RegAck), 32'd0);
        check("unmapped_out", 32'(RegOut), 32'd0);

        // Low byte stages only, high byte commits
        bus_write(8'hD2, 8'h34);
        check("lo_only_w1", 32'(win(1)), 32'h3FF);
        lit_read("lo_only_d2", 8'hD2, 8'hFF);
        bus_write(8'hD3, 8'h01);
        check("commit_w1", 32'(win(1)), 32'h134);
        lit_read("commit_d2", 8'hD2, 8'h34);
        lit_read("commit_d3", 8'hD3, 8'h01);

        // High-only write keeps the low byte
        bus_write(8'hD3, 8'h02);
        check("honly_w1", 32'(win(1)), 32'h234);

        // Masking on window 1 only
        bus_write(8'hE4, 8'h0F);
        bus_write(8'hE5, 8'h00);
        bus_write(8'hE6, 8'h02);
        check("mask_w1", 32'(win(1)), 32'h004);
        check("mask_w0", 32'(win(0)), 32'h3FF);

`ifdef BANK_MAPPER_LOCK_EN
        bus_write(8'hE7, 8'h00);
        check("lock_set", 32'(Locked), 32'd1);
        bus_write(8'hE4, 8'h00);
        lit_read("lock_mask_kept", 8'hE4, 8'h0F);
        bus_write(8'hE7, 8'hA5);
        bus_write(8'hD0, 8'h11);
        bus_write(8'hE7, 8'h5A);
        check("lock_broken_seq", 32'(Locked), 32'd1);
        bus_write(8'hE7, 8'hA5);
        bus_write(8'hE7, 8'h5A);
        check("lock_released", 32'(Locked), 32'd0);
        bus_write(8'hE4, 8'hFF);
        lit_read("unlock_mask_wr", 8'hE4, 8'hFF);
`else
        bus_write(8'hE7, 8'h00);
        check("nolock_locked", 32'(Locked), 32'd0);
        lit_read("nolock_e7", 8'hE7, 8'h00);
`endif

        // Randomised writes with readback after each
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 11);
            a = (sel < 10) ? addrs[sel] : 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            if (a == 8'hE7 && $urandom_range(0, 3) != 0) d = keys[$urandom_range(0, 2)];
            bus_write(a, d);
            sel = $urandom_range(0, 11);
            check_read((sel < 10) ? addrs[sel] : 8'($urandom_range(0, 255)));
        end

        // Reset between nWE fall and rise discards the pending write
        bus_write(8'hD2, 8'h55);
        @(negedge clk);
        RegAddr = 8'hD3; WriteData = 8'h02;
        nSel = 1'b0; nIO = 1'b0; nWE = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 Reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        nWE = 1'b1;
        repeat (3) @(negedge clk);
        nSel = 1'b1; nIO = 1'b1;
        @(posedge clk);
        #2 Reset = 1'b0;
        repeat (6) @(negedge clk);
        check("rstmid_w1", 32'(win(1)), 32'h3FF);
        lit_read("rstmid_d2", 8'hD2, 8'hFF);
        lit_read("rstmid_d3", 8'hD3, 8'h03);

        // Normal operation resumes; staging came back as all ones
        bus_write(8'hD3, 8'h01);
        check("post_rst_w1", 32'(win(1)), 32'h1FF);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bank_mapper.md
# bank_mapper

Parametrised bank register file and masking unit: the successor to the fixed three-window cartridge mapper. It holds NUM_WINDOWS bank registers, each BANK_WIDTH bits wide, and commits 16-bit updates atomically. Bank masks are per window, and an optional key-sequence lock protects the masks. It runs in the FastClk domain, takes the cartridge I/O write strobe through a synchroniser, and drives registered masked bank numbers to the address-extension logic.

## Interface
- NUM_WINDOWS, 3: bank windows (1..8); window 0 = RAM, 1 = ROM0, 2 = ROM1.
- BANK_WIDTH, 10: bank register width (9..16).
- REG_BASE, 8'hD0: window n low byte at REG_BASE+2n, high byte at REG_BASE+2n+1.
- MASK_BASE, 8'hE4: mask low at +0, mask high at +1, apply bits at +2, LOCK at +3.
- FastClk  in  1  block clock.
- Reset  in  1  asynchronous, active-high reset.
- nSel, nIO, nWE  in  1 each  raw cartridge bus strobes, active low.
- RegAddr  in  8  {AddrHi, AddrLo[3:0]}.
- WriteData  in  8  Data[7:0].
- BankOut  out  NUM_WINDOWS*BANK_WIDTH  masked bank per window, registered; window n at [n*BANK_WIDTH +: BANK_WIDTH].
- RegOut  out  8  readback byte, combinational.
- RegAck  out  1  RegAddr hits a register of this block, combinational.
- Locked  out  1  mask registers write-protected.

## Operation
- Write detect:
  - IOWrite = ~nSel & ~nIO & ~nWE goes through a 2-flop synchroniser.
  - A commit pulse fires on the synchronised falling edge of IOWrite, i.e. on the rising edge of nWE.
  - The capture register loads {RegAddr, WriteData} on every edge where sync stage 1 is high.
  - The commit uses the last captured value.
- Bank L write: loads the window's staging byte only. The bank register is unchanged.
- Bank H write: commits bank = {WriteData[BANK_WIDTH-9:0], staging} atomically. Staging then reloads from the new committed low byte, so an H-only write preserves the low byte.
- Mask registers:
  - mask is BANK_WIDTH bits: low byte at +0, high bits at +1.
  - apply[NUM_WINDOWS-1:0] is at +2.
  - BankOut[n] = apply[n] ? bank[n] & mask : bank[n].
- Readback:
  - Bank L/H reads return committed bits, never staging.
  - Unused high bits read 0.
  - RegAck is 0 outside the mapped range, and RegOut is then 0.
- Reset values: every bank register all ones; staging all ones; mask all ones; apply all ones; BankOut all ones; capture 0; Locked 0.
- Writes to unmapped addresses are ignored, apart from the lock FSM rule below.

## Timing
- Edge 0 is the first FastClk edge that samples nWE high. The register commits at edge 2, and BankOut updates at edge 3.
- Commits require at least 4 FastClk periods between successive nWE rises; the bus cycle guarantees this.
- Capture requires the bus to hold address and data stable for at least 2 FastClk periods before the nWE rise.
- Reset asserted mid-write discards the pending capture and staging. No commit may occur on the first synchronised edge after reset release; the synchroniser resets to "idle".
- Register and lock updates happen only on the commit pulse.

## Configuration
- BANK_MAPPER_LOCK_EN defined:
  - Lock FSM states: UNLOCKED (reset), KEY1, LOCKED.
  - UNLOCKED: write 8'h00 to LOCK → LOCKED.
  - LOCKED: write 8'hA5 to LOCK → KEY1.
  - KEY1: write 8'h5A to LOCK → UNLOCKED. Any other commit (any address or value) → LOCKED.
  - While not UNLOCKED, writes to mask and apply are dropped. Bank writes are always accepted.
  - LOCK reads {7'h0, Locked}; Locked is 0 only in UNLOCKED.
- BANK_MAPPER_LOCK_EN undefined:
  - No FSM; Locked is tied to 0.
  - LOCK writes are ignored, and LOCK reads as 0 with RegAck 1.

## Structure
- bank_mapper_pkg holds:
  - the lock_state_t enum;
  - the key constants LOCK_KEY_1 = 8'hA5, LOCK_KEY_2 = 8'h5A and LOCK_CMD = 8'h00;
  - the default REG_BASE and MASK_BASE values.
- Sub-module bus_write_sync: 2-flop synchroniser, edge detect and capture register. Outputs are the commit pulse, captured address and captured data.

## Test plan
- Reset → BankOut all ones for every window; Locked = 0; reading REG_BASE+1 gives 8'h03 with RegAck 1.
- Write 8'h34 to D2, then 8'h01 to D3 → window 1 bank = 10'h134. BankOut must not change after the D2 write alone. BankOut updates exactly 3 edges after nWE is sampled high.
- Mask: write 8'h0F to E4, 8'h00 to E5, apply = 3'b010 → window 1 BankOut = 10'h004, window 0 BankOut unmasked.
- H-only write: after bank = 10'h134, write 8'h02 to D3 → window 1 bank = 10'h234.
- Lock (LOCK_EN):
  - Write 00 to E7, then 8'h00 to E4 → mask unchanged, Locked = 1.
  - Write A5, then D0 (bank write), then 5A → still locked.
  - Write A5, then 5A → Locked = 0.
- Reset asserted between the nWE fall and rise of an H write → no commit; bank stays 10'h3FF.
